// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential signed Q1.7 multiplier.
package seq_multiplier_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned FRAC_W = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/Busy/Done handshake plus operand and result buses of the multiplier.
interface seq_multiplier_if
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
);

    logic               Start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               Busy;
    logic               Done;
    logic [WIDTH-1:0]   Result;
    logic [2*WIDTH-1:0] Product;

    // Controller side: issues requests, observes status and results.
    modport master (
        output Start, A, B,
        input  Busy, Done, Result, Product
    );

    // Multiplier side.
    modport slave (
        input  Start, A, B,
        output Busy, Done, Result, Product
    );

endinterface

// File: rtl/seq_multiplier_datapath.sv
// Shift-add datapath: operand magnitudes, accumulation, sign fix-up and Q1.7 result
// formatting. Define MULT_ROUND_EN for round-half-up results; default truncates.
module seq_multiplier_datapath
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     i_load,
    input  logic                     i_step,
    input  logic                     i_last,
    input  logic [$clog2(WIDTH)-1:0] i_count,
    input  logic [WIDTH-1:0]         i_a,
    input  logic [WIDTH-1:0]         i_b,
    output logic [2*WIDTH-1:0]       o_product,
    output logic [WIDTH-1:0]         o_result
);

    localparam int unsigned PROD_BITS = 2 * WIDTH;
    // Only -1.0 x -1.0 produces +1.0, which Q1.7 cannot hold.
    localparam logic [PROD_BITS-1:0] SAT_PROD = PROD_BITS'(1) << (PROD_BITS - 2);
    localparam logic [WIDTH-1:0]     MAX_POS  = {1'b0, {(WIDTH - 1){1'b1}}};

    // One extra bit so that the most negative operand has a representable magnitude.
    function automatic logic [WIDTH:0] f_mag(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? (~ext + 1'b1) : ext;
    endfunction

    logic [WIDTH:0]     r_mag_a;
    logic [WIDTH:0]     r_mag_b;
    logic               r_sign;
    logic [PROD_BITS-1:0] r_acc;
    logic [PROD_BITS-1:0] r_product;
    logic [WIDTH-1:0]   r_result;

    logic [PROD_BITS-1:0] w_addend;
    logic [PROD_BITS-1:0] w_acc_next;
    logic [PROD_BITS-1:0] w_prod_next;
    logic [PROD_BITS-1:0] w_rounded;
    logic [WIDTH-1:0]     w_result_next;

    // Partial product for this iteration and the signed product it would complete.
    always_comb begin
        w_addend    = r_mag_b[0] ? ({{(WIDTH - 1){1'b0}}, r_mag_a} << i_count) : '0;
        w_acc_next  = r_acc + w_addend;
        w_prod_next = r_sign ? (~w_acc_next + 1'b1) : w_acc_next;
    end

    // Q2.14 -> Q1.7: drop the redundant sign bit and the low fraction bits.
    always_comb begin
`ifdef MULT_ROUND_EN
        w_rounded = w_prod_next + (PROD_BITS'(1) << (WIDTH - 2));
`else
        w_rounded = w_prod_next;
`endif
        w_result_next = (w_prod_next == SAT_PROD) ? MAX_POS : WIDTH'(w_rounded >> (WIDTH - 1));
    end

    // Operand capture, one shift-add step per clock, outputs updated only on completion.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_sign    <= 1'b0;
            r_acc     <= '0;
            r_product <= '0;
            r_result  <= '0;
        end else if (i_load) begin
            r_mag_a <= f_mag(i_a);
            r_mag_b <= f_mag(i_b);
            r_sign  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_acc   <= '0;
        end else if (i_step) begin
            r_acc   <= w_acc_next;
            r_mag_b <= r_mag_b >> 1;
            if (i_last) begin
                r_product <= w_prod_next;
                r_result  <= w_result_next;
            end
        end
    end

    assign o_product = r_product;
    assign o_result  = r_result;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed Q1.7 multiplier: FSM and bit counter around the shift-add datapath.
// One operation takes 9 cycles from the Start edge to the Done pulse.
// Define MULT_ROUND_EN for round-half-up results; default truncates toward -inf.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input logic            Clock,
    input logic            nReset,
    seq_multiplier_if.slave bus
);

    localparam int unsigned           CNT_BITS = $clog2(WIDTH);
    localparam logic [CNT_BITS-1:0]   LAST_CNT = CNT_BITS'(WIDTH - 1);

    mult_state_t         r_state;
    logic [CNT_BITS-1:0] r_count;
    logic                r_busy;
    logic                r_done;

    logic                w_load;
    logic                w_step;
    logic                w_last;
    logic [2*WIDTH-1:0]  w_product;
    logic [WIDTH-1:0]    w_result;

    // Start is honoured from IDLE and DONE only; requests during RUN are dropped.
    assign w_load = (r_state != RUN) && bus.Start;
    assign w_step = (r_state == RUN);
    assign w_last = w_step && (r_count == LAST_CNT);

    // Control FSM with registered Busy/Done mirroring the next state.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        r_state <= RUN;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_CNT) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    seq_multiplier_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .Clock     (Clock),
        .nReset    (nReset),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_last    (w_last),
        .i_count   (r_count),
        .i_a       (bus.A),
        .i_b       (bus.B),
        .o_product (w_product),
        .o_result  (w_result)
    );

    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;
    assign bus.Product = w_product;
    assign bus.Result  = w_result;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed literal cases, then random traffic compared every
// cycle against an arithmetic model of the operation timeline.
module tb_seq_multiplier;

    logic clk  = 1'b0;
    logic nrst = 1'b1;

    int checks = 0;
    int errors = 0;
    int model_done_cnt = 0;

`ifdef MULT_ROUND_EN
    localparam logic [7:0] X_RES_0316 = 8'h01;
    localparam logic [7:0] X_RES_5533 = 8'h22;
    localparam logic [7:0] X_RES_7F81 = 8'h82;
`else
    localparam logic [7:0] X_RES_0316 = 8'h00;
    localparam logic [7:0] X_RES_5533 = 8'h21;
    localparam logic [7:0] X_RES_7F81 = 8'h81;
`endif

    seq_multiplier_if #(.WIDTH(8)) u_bus ();

    seq_multiplier #(
        .WIDTH (8)
    ) u_dut (
        .Clock  (clk),
        .nReset (nrst),
        .bus    (u_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: exact signed product, then Q1.7 with saturation.
    function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    function automatic logic [7:0] model_res(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        if (p == 16384) return 8'h7F;
`ifdef MULT_ROUND_EN
        p = p + 64;
`endif
        p = p >>> 7;
        return p[7:0];
    endfunction

    function automatic logic [7:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Timeline model: an accepted request completes 8 edges later.
    int          m_left = 0;
    logic [15:0] m_pend_prod = '0;
    logic [7:0]  m_pend_res = '0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [15:0] exp_prod = '0;
    logic [7:0]  exp_res = '0;

    initial begin : model
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) begin
                m_left   = 0;
                exp_busy = 1'b0;
                exp_done = 1'b0;
                exp_prod = '0;
                exp_res  = '0;
            end else begin
                exp_done = 1'b0;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        exp_done = 1'b1;
                        exp_prod = m_pend_prod;
                        exp_res  = m_pend_res;
                        model_done_cnt++;
                    end
                end else if (u_bus.Start) begin
                    m_left      = 8;
                    m_pend_prod = model_prod(u_bus.A, u_bus.B);
                    m_pend_res  = model_res(u_bus.A, u_bus.B);
                end
                exp_busy = (m_left > 0);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("cyc_busy", {15'd0, u_bus.Busy}, {15'd0, exp_busy});
            check("cyc_done", {15'd0, u_bus.Done}, {15'd0, exp_done});
            check("cyc_product", u_bus.Product, exp_prod);
            check("cyc_result", {8'd0, u_bus.Result}, {8'd0, exp_res});
        end
    end

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!u_bus.Done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] xp,
                         input logic [7:0] xr, input string name);
        int cyc;
        check({name, "_model_prod"}, model_prod(a, b), xp);
        check({name, "_model_res"}, {8'd0, model_res(a, b)}, {8'd0, xr});
        @(negedge clk);
        u_bus.Start = 1'b1;
        u_bus.A     = a;
        u_bus.B     = b;
        @(negedge clk);
        u_bus.Start = 1'b0;
        u_bus.A     = 8'($urandom);
        u_bus.B     = 8'($urandom);
        wait_done(cyc);
        check({name, "_latency"}, 16'(cyc), 16'd9);
        check({name, "_product"}, u_bus.Product, xp);
        check({name, "_result"}, {8'd0, u_bus.Result}, {8'd0, xr});
    endtask

    initial begin : driver
        int cyc;
        u_bus.Start = 1'b0;
        u_bus.A     = '0;
        u_bus.B     = '0;
        #1 nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {15'd0, u_bus.Busy}, 16'd0);
        check("rst_done", {15'd0, u_bus.Done}, 16'd0);
        check("rst_result", {8'd0, u_bus.Result}, 16'd0);
        check("rst_product", u_bus.Product, 16'd0);
        #2 nrst = 1'b1;

        do_op(8'h40, 8'h40, 16'h1000, 8'h20, "half_x_half");

        // Abort an operation four cycles in.
        @(negedge clk);
        u_bus.Start = 1'b1;
        u_bus.A     = 8'h55;
        u_bus.B     = 8'h33;
        @(negedge clk);
        u_bus.Start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_busy", {15'd0, u_bus.Busy}, 16'd1);
        #2 nrst = 1'b0;
        #1;
        check("abort_busy", {15'd0, u_bus.Busy}, 16'd0);
        check("abort_done", {15'd0, u_bus.Done}, 16'd0);
        check("abort_result", {8'd0, u_bus.Result}, 16'd0);
        check("abort_product", u_bus.Product, 16'd0);
        @(negedge clk);
        #2 nrst = 1'b1;

        do_op(8'h55, 8'h33, 16'h10EF, X_RES_5533, "after_abort");
        do_op(8'hC0, 8'h40, 16'hF000, 8'hE0, "neg_x_pos");
        do_op(8'h80, 8'h03, 16'hFE80, 8'hFD, "min_x_3");
        do_op(8'h80, 8'h80, 16'h4000, 8'h7F, "min_x_min_sat");
        do_op(8'h7F, 8'h7F, 16'h3F01, 8'h7E, "max_x_max");
        do_op(8'h03, 8'h16, 16'h0042, X_RES_0316, "round_case");
        do_op(8'h00, 8'h5A, 16'h0000, 8'h00, "zero_operand");

        // Start held through RUN is ignored; still high in DONE it launches the next op.
        @(negedge clk);
        u_bus.Start = 1'b1;
        u_bus.A     = 8'h40;
        u_bus.B     = 8'hC0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("hs_busy", {15'd0, u_bus.Busy}, 16'd1);
            check("hs_no_done", {15'd0, u_bus.Done}, 16'd0);
            u_bus.A = 8'($urandom);
            u_bus.B = 8'($urandom);
        end
        @(negedge clk);
        check("hs_done", {15'd0, u_bus.Done}, 16'd1);
        check("hs_product", u_bus.Product, 16'hF000);
        check("hs_result", {8'd0, u_bus.Result}, 16'h00E0);
        u_bus.A = 8'h7F;
        u_bus.B = 8'h81;
        @(negedge clk);
        check("b2b_busy", {15'd0, u_bus.Busy}, 16'd1);
        check("b2b_no_done", {15'd0, u_bus.Done}, 16'd0);
        u_bus.Start = 1'b0;
        u_bus.A     = 8'($urandom);
        u_bus.B     = 8'($urandom);
        wait_done(cyc);
        check("b2b_latency", 16'(cyc), 16'd9);
        check("b2b_product", u_bus.Product, 16'hC0FF);
        check("b2b_result", {8'd0, u_bus.Result}, {8'd0, X_RES_7F81});

        // Random traffic with one asynchronous reset in the middle.
        model_done_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            u_bus.Start = ($urandom_range(0, 3) == 0);
            u_bus.A     = pick_operand();
            u_bus.B     = pick_operand();
            if (i == 1500) begin
                #2 nrst = 1'b0;
                @(negedge clk);
                #2 nrst = 1'b1;
            end
        end
        @(negedge clk);
        u_bus.Start = 1'b0;
        repeat (12) @(negedge clk);
        check("rand_ops_completed", {15'd0, model_done_cnt > 100}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
